// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for a single-port RAM: instruction fetch (read) and load/store (read/write).
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module ram_port_arbiter #(
    parameter int AW             = 16,
    parameter int DW             = 16,
    parameter int LATENCY        = 1,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic          clk,
    input  logic          init,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("ram_port_arbiter: LATENCY out of range 1..15");
    end
    if (MAX_DATA_BURST < 1) begin : g_bad_burst
        $error("ram_port_arbiter: MAX_DATA_BURST must be at least 1");
    end

    state_t     state;
    state_t     state_next;
    logic [3:0] acc_cnt;
    logic       owner_d;
    logic       lat_we;
    logic       grant;
    logic       grant_d;
    logic       last_access;
    logic       fetch_forced;

`ifdef ARB_STARVE_GUARD_EN
    localparam int BW = (MAX_DATA_BURST < 1) ? 1 : $clog2(MAX_DATA_BURST + 1);
    logic [BW-1:0] burst_cnt;

    assign fetch_forced = if_req && (burst_cnt == BW'(MAX_DATA_BURST));

    // Count data grants made while fetch is waiting; any fetch grant or fetch absence clears it.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            burst_cnt <= '0;
        end else if (state == IDLE) begin
            if (!if_req) begin
                burst_cnt <= '0;
            end else if (grant && !grant_d) begin
                burst_cnt <= '0;
            end else if (grant_d) begin
                burst_cnt <= burst_cnt + BW'(1);
            end
        end
    end
`else
    assign fetch_forced = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and grant decision.
    always_comb begin
        state_next  = state;
        grant       = 1'b0;
        grant_d     = 1'b0;
        last_access = (state == ACCESS) && (acc_cnt == LAST_CNT);
        case (state)
            IDLE: begin
                if (d_req || if_req) begin
                    grant      = 1'b1;
                    grant_d    = d_req && !fetch_forced;
                    state_next = ACCESS;
                end else begin
                    state_next = IDLE;
                end
            end
            ACCESS: begin
                if (last_access) begin
                    state_next = DONE;
                end else begin
                    state_next = ACCESS;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered RAM strobes, acks and read data; values are set up one edge ahead of each state.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            acc_cnt   <= 4'd0;
            owner_d   <= 1'b0;
            lat_we    <= 1'b0;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            busy      <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner_d   <= grant_d;
                        lat_we    <= grant_d && d_we;
                        acc_cnt   <= 4'd0;
                        mem_addr  <= grant_d ? d_addr : if_addr;
                        mem_re    <= !(grant_d && d_we);
                        mem_we    <= grant_d && d_we;
                        mem_wdata <= (grant_d && d_we) ? d_wdata : '0;
                        busy      <= 1'b1;
                    end
                end
                ACCESS: begin
                    acc_cnt <= acc_cnt + 4'd1;
                    mem_we  <= 1'b0;
                    if (last_access) begin
                        mem_re <= 1'b0;
                        if (owner_d) begin
                            d_ack <= 1'b1;
                            if (!lat_we) begin
                                d_rdata <= mem_rdata;
                            end
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                DONE:    busy <= 1'b0;
                default: busy <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter: one LATENCY=1 instance and one LATENCY=3 instance.
module tb_ram_port_arbiter;

    logic clk = 1'b0;
    logic init;
    always #5 clk = ~clk;

    logic        if_req, d_req, d_we;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic        if_ack, d_ack, mem_re, mem_we, busy;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        if_req3, d_req3, d_we3;
    logic [15:0] if_addr3, d_addr3, d_wdata3;
    logic        if_ack3, d_ack3, mem_re3, mem_we3, busy3;
    logic [15:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

    logic [15:0] ram1 [0:255];
    logic [15:0] ram3 [0:255];

    int vectors    = 0;
    int miscompares = 0;

    ram_port_arbiter #(.AW(16), .DW(16), .LATENCY(1), .MAX_DATA_BURST(4)) u1 (
        .clk(clk), .init(init),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    ram_port_arbiter #(.AW(16), .DW(16), .LATENCY(3), .MAX_DATA_BURST(4)) u3 (
        .clk(clk), .init(init),
        .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3), .if_rdata(if_rdata3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
        .d_ack(d_ack3), .d_rdata(d_rdata3),
        .mem_addr(mem_addr3), .mem_re(mem_re3), .mem_we(mem_we3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3), .busy(busy3)
    );

    assign mem_rdata  = ram1[mem_addr[7:0]];
    assign mem_rdata3 = ram3[mem_addr3[7:0]];

    always @(posedge clk) begin
        if (mem_we)  ram1[mem_addr[7:0]]  <= mem_wdata;
        if (mem_we3) ram3[mem_addr3[7:0]] <= mem_wdata3;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        init = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 16'h0000; d_addr = 16'h0000; d_wdata = 16'h0000;
        if_req3 = 1'b0; d_req3 = 1'b0; d_we3 = 1'b0;
        if_addr3 = 16'h0000; d_addr3 = 16'h0000; d_wdata3 = 16'h0000;
        tick();
        tick();
        init = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        init = 1'b1;
        tick();
        vectors++;
        if ({if_ack, d_ack, mem_re, mem_we, busy, mem_addr, mem_wdata, if_rdata, d_rdata} !== 69'd0) begin
            miscompares++;
            $display("FAIL reset_u1: got %h want 0", {if_ack, d_ack, mem_re, mem_we, busy, mem_addr, mem_wdata, if_rdata, d_rdata});
        end
        vectors++;
        if ({if_ack3, d_ack3, mem_re3, mem_we3, busy3, mem_addr3, mem_wdata3, if_rdata3, d_rdata3} !== 69'd0) begin
            miscompares++;
            $display("FAIL reset_u3: got %h want 0", {if_ack3, d_ack3, mem_re3, mem_we3, busy3, mem_addr3, mem_wdata3, if_rdata3, d_rdata3});
        end
        init = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        do_reset();
        if_req = 1'b1; if_addr = 16'h0010;
        tick();
        vectors++;
        if ({mem_re, mem_we, if_ack, busy, mem_addr} !== {4'b1001, 16'h0010}) begin
            miscompares++;
            $display("FAIL fetch_access: got re=%b we=%b ack=%b busy=%b addr=%h want 1 0 0 1 0010", mem_re, mem_we, if_ack, busy, mem_addr);
        end
        tick();
        vectors++;
        if ({if_ack, d_ack, mem_re, if_rdata} !== {3'b100, 16'h01A5}) begin
            miscompares++;
            $display("FAIL fetch_done: got ack=%b dack=%b re=%b rdata=%h want 1 0 0 01a5", if_ack, d_ack, mem_re, if_rdata);
        end
        if_req = 1'b0;
        tick();
        vectors++;
        if ({if_ack, busy, if_rdata} !== {2'b00, 16'h01A5}) begin
            miscompares++;
            $display("FAIL fetch_after: got ack=%b busy=%b rdata=%h want 0 0 01a5", if_ack, busy, if_rdata);
        end
    endtask

    task automatic test_store_load();
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
        tick();
        tick();
        vectors++;
        if ({d_ack, d_rdata} !== {1'b1, 16'h1234}) begin
            miscompares++;
            $display("FAIL preload_load: got ack=%b rdata=%h want 1 1234", d_ack, d_rdata);
        end
        d_req = 1'b0;
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
        tick();
        vectors++;
        if ({mem_we, mem_re, mem_addr, mem_wdata} !== {2'b10, 16'h0040, 16'hBEEF}) begin
            miscompares++;
            $display("FAIL store_access: got we=%b re=%b addr=%h wdata=%h want 1 0 0040 beef", mem_we, mem_re, mem_addr, mem_wdata);
        end
        tick();
        vectors++;
        if ({d_ack, mem_we, d_rdata} !== {2'b10, 16'h1234}) begin
            miscompares++;
            $display("FAIL store_done: got ack=%b we=%b rdata=%h want 1 0 1234", d_ack, mem_we, d_rdata);
        end
        d_req = 1'b0; d_we = 1'b0;
        tick();
        d_req = 1'b1;
        tick();
        tick();
        vectors++;
        if ({d_ack, mem_we, d_rdata} !== {2'b10, 16'hBEEF}) begin
            miscompares++;
            $display("FAIL load_back: got ack=%b we=%b rdata=%h want 1 0 beef", d_ack, mem_we, d_rdata);
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_priority();
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0002;
        if_req = 1'b1; if_addr = 16'h0003;
        tick();
        vectors++;
        if ({mem_re, mem_addr} !== {1'b1, 16'h0002}) begin
            miscompares++;
            $display("FAIL prio_first_grant: got re=%b addr=%h want 1 0002", mem_re, mem_addr);
        end
        tick();
        vectors++;
        if ({d_ack, if_ack, d_rdata} !== {2'b10, 16'h2222}) begin
            miscompares++;
            $display("FAIL prio_d_ack: got dack=%b iack=%b rdata=%h want 1 0 2222", d_ack, if_ack, d_rdata);
        end
        d_req = 1'b0;
        tick();
        vectors++;
        if ({mem_re, busy, if_ack} !== 3'b000) begin
            miscompares++;
            $display("FAIL prio_gap: got re=%b busy=%b iack=%b want 0 0 0", mem_re, busy, if_ack);
        end
        tick();
        vectors++;
        if ({mem_re, mem_addr} !== {1'b1, 16'h0003}) begin
            miscompares++;
            $display("FAIL prio_second_grant: got re=%b addr=%h want 1 0003", mem_re, mem_addr);
        end
        tick();
        vectors++;
        if ({if_ack, d_ack, if_rdata} !== {2'b10, 16'h3333}) begin
            miscompares++;
            $display("FAIL prio_if_ack: got iack=%b dack=%b rdata=%h want 1 0 3333", if_ack, d_ack, if_rdata);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_burst();
        string exp_s;
        byte   got [10];
        int    n;
`ifdef ARB_STARVE_GUARD_EN
        exp_s = "DDDDFDDDDF";
`else
        exp_s = "DDDDDDDDDD";
`endif
        do_reset();
        n = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0002;
        if_req = 1'b1; if_addr = 16'h0003;
        for (int c = 0; c < 60 && n < 10; c++) begin
            tick();
            if (d_ack) begin
                got[n] = "D";
                n++;
            end else if (if_ack) begin
                got[n] = "F";
                n++;
            end
        end
        vectors++;
        if (n != 10) begin
            miscompares++;
            $display("FAIL burst_count: got %0d grants want 10", n);
        end
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (got[i] !== exp_s[i]) begin
                miscompares++;
                $display("FAIL burst_order[%0d]: got %c want %c", i, got[i], exp_s[i]);
            end
        end
        d_req = 1'b0; if_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_init_mid_access();
        int cycles;
        do_reset();
        if_req3 = 1'b1; if_addr3 = 16'h0010;
        tick();
        tick();
        vectors++;
        if ({busy3, mem_re3, mem_addr3} !== {2'b11, 16'h0010}) begin
            miscompares++;
            $display("FAIL init_pre: got busy=%b re=%b addr=%h want 1 1 0010", busy3, mem_re3, mem_addr3);
        end
        init = 1'b1;
        #1;
        vectors++;
        if ({if_ack3, d_ack3, mem_re3, mem_we3, busy3, mem_addr3, mem_wdata3, if_rdata3, d_rdata3} !== 69'd0) begin
            miscompares++;
            $display("FAIL init_async_clear: got %h want 0", {if_ack3, d_ack3, mem_re3, mem_we3, busy3, mem_addr3, mem_wdata3, if_rdata3, d_rdata3});
        end
        tick();
        vectors++;
        if (if_ack3 !== 1'b0) begin
            miscompares++;
            $display("FAIL init_no_ack: got %b want 0", if_ack3);
        end
        init = 1'b0;
        cycles = 0;
        while (cycles < 12 && if_ack3 !== 1'b1) begin
            tick();
            cycles++;
        end
        vectors++;
        if (cycles != 4) begin
            miscompares++;
            $display("FAIL init_reissue_latency: got %0d cycles want 4", cycles);
        end
        vectors++;
        if (if_rdata3 !== 16'h0A5A) begin
            miscompares++;
            $display("FAIL init_reissue_data: got %h want 0a5a", if_rdata3);
        end
        if_req3 = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        if_req = 1'b1; if_addr = 16'h0010;
        tick();
        tick();
        vectors++;
        if ({if_ack, if_rdata} !== {1'b1, 16'h01A5}) begin
            miscompares++;
            $display("FAIL b2b_first: got ack=%b rdata=%h want 1 01a5", if_ack, if_rdata);
        end
        if_addr = 16'h0011;
        tick();
        vectors++;
        if ({busy, mem_re, if_ack} !== 3'b000) begin
            miscompares++;
            $display("FAIL b2b_no_grant_in_done: got busy=%b re=%b ack=%b want 0 0 0", busy, mem_re, if_ack);
        end
        tick();
        vectors++;
        if ({mem_re, mem_addr} !== {1'b1, 16'h0011}) begin
            miscompares++;
            $display("FAIL b2b_second_grant: got re=%b addr=%h want 1 0011", mem_re, mem_addr);
        end
        tick();
        vectors++;
        if ({if_ack, if_rdata} !== {1'b1, 16'h1111}) begin
            miscompares++;
            $display("FAIL b2b_second: got ack=%b rdata=%h want 1 1111", if_ack, if_rdata);
        end
        if_req = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram1[i] = 16'h0000;
            ram3[i] = 16'h0000;
        end
        ram1[8'h10] = 16'h01A5;
        ram1[8'h11] = 16'h1111;
        ram1[8'h20] = 16'h1234;
        ram1[8'h02] = 16'h2222;
        ram1[8'h03] = 16'h3333;
        ram3[8'h10] = 16'h0A5A;
        do_reset();
        test_reset();
        test_fetch();
        test_store_load();
        test_priority();
        test_burst();
        test_init_mid_access();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port data RAM between two requesters: instruction fetch (read-only) and the load/store path (read/write).
- Sits between the fetch unit / load-store control and the RAM.
- Serialises accesses and models a fixed RAM access latency; each transaction is acknowledged with a one-cycle pulse.
- Load/store normally has priority; an optional guard bounds how long fetch can be starved.

Parameters:
- AW, 16, address width
- DW, 16, data width
- LATENCY, 1, RAM access cycles per transaction (legal range 1..15)
- MAX_DATA_BURST, 4, consecutive data grants allowed while fetch waits (guard only, legal ≥1)

Ports:
- clk  in  1  system clock, rising edge
- init  in  1  asynchronous active-high reset
- if_req  in  1  fetch read request; held with stable if_addr until if_ack
- if_addr  in  AW  fetch address
- if_ack  out  1  one-cycle pulse, fetch done
- if_rdata  out  DW  fetch read data, valid while if_ack=1, held after
- d_req  in  1  load/store request; held with stable d_we/d_addr/d_wdata until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  AW  load/store address
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle pulse, load/store done
- d_rdata  out  DW  load data, valid while d_ack=1, held after
- mem_addr  out  AW  RAM address
- mem_re  out  1  RAM read enable
- mem_we  out  1  RAM write enable
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid in last ACCESS cycle
- busy  out  1  high in ACCESS and DONE

Behaviour:
- Reset values: state IDLE; all outputs 0, including if_rdata, d_rdata and mem_addr. Burst counter 0.
- State IDLE:
  - If no request, stay in IDLE.
  - Otherwise pick the owner by the priority rule.
  - Latch owner, address, we and wdata; clear the access counter; go to ACCESS.
- Priority rule (no guard):
  - d_req wins over if_req.
  - If only one request is present, that requester wins.
- State ACCESS, lasting exactly LATENCY cycles:
  - mem_addr = latched address throughout.
  - Load/fetch: mem_re=1 in every ACCESS cycle.
  - Store: mem_we=1 in the first ACCESS cycle only; mem_re=0 throughout.
  - mem_wdata = latched wdata during stores, 0 otherwise.
  - On the last ACCESS cycle, capture mem_rdata into the owner's rdata register (reads only) and go to DONE.
- State DONE, one cycle:
  - Owner's ack=1 and its rdata is valid.
  - No grant is made in DONE.
  - Next state is IDLE.
- Latency: request seen in IDLE at cycle T → ack in cycle T+LATENCY+1. Back-to-back throughput is one transaction per LATENCY+2 cycles.
- Requester drops req in the cycle after ack, or keeps it high to issue a new transaction. A req still high in IDLE is a new request.
- Store ack: d_ack pulses; d_rdata is unchanged.
- Outside ACCESS: mem_re=0 and mem_we=0; mem_addr and mem_wdata hold their last values.
- Requests changing during ACCESS/DONE are ignored; the latched values are used.
- init asserted mid-transaction: the transaction is dropped, no ack is issued, and outputs return to reset values immediately. A write already issued to RAM is not undone.
- Simultaneous if_req and d_req with the burst limit reached: see Optional Feature.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - The burst counter increments on each data grant made while if_req=1.
  - It clears on any fetch grant, and on any IDLE cycle where if_req=0.
  - When the counter equals MAX_DATA_BURST and both requests are present, fetch is granted.
- Undefined: strict data priority; no counter is present.

Test Plan:
- LATENCY=1, if_req=1, if_addr=0x0010, RAM[0x10]=0x01A5 → mem_re high for one cycle, if_ack pulse 2 cycles after request, if_rdata=0x01A5.
- Store d_we=1, d_addr=0x0040, d_wdata=0xBEEF, then load 0x0040 → mem_we high exactly one cycle; load returns d_rdata=0xBEEF; d_rdata unchanged after the store ack.
- if_req and d_req asserted together (load 0x0002, fetch 0x0003) → d_ack first, if_ack LATENCY+2 cycles later; no overlap of mem_re windows.
- ARB_STARVE_GUARD_EN, MAX_DATA_BURST=4, d_req and if_req held high continuously → grant order D,D,D,D,F,D,D,D,D,F; without the macro, fetch is never granted.
- LATENCY=3, init pulsed during the second ACCESS cycle of a fetch → if_ack never asserts, all outputs 0 in the same cycle; after release, a re-issued fetch completes in 4 cycles.
- if_req held high across if_ack with a new if_addr → the second fetch is granted in the IDLE cycle after DONE with the new address; no grant occurs during DONE.
